ts_header_parser: RTL and testbench
===================================

Name: ts_header_parser

Overview:
Sits directly downstream of the per-channel sync recovery stage and consumes its byte_out/valid/sync stream. It frames 188-byte MPEG-2 TS packets and decodes the 4-byte header. It checks the continuity counter (CC) of one selected PID and forwards that PID's payload bytes. It also keeps packet and error statistics for the QoS monitor.

Parameters:
FILTER_PID, 13'h0100, PID whose CC is checked and whose payload is forwarded
PKT_LEN, 188, TS packet length in bytes including sync byte
CNT_W, 16, width of statistics counters

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
byte_in  input  8  TS byte from sync recovery
byte_valid  input  1  byte_in valid this cycle
sync_in  input  1  high together with the 0x47 sync byte while upstream is locked
hdr_valid  output  1  one-cycle pulse; header fields below are valid
pid  output  13  PID of last header
tei  output  1  transport error indicator
pusi  output  1  payload unit start indicator
tsc  output  2  transport scrambling control
afc  output  2  adaptation field control
cc  output  4  continuity counter
cc_error  output  1  one-cycle pulse with hdr_valid on a CC discontinuity of FILTER_PID
sync_err  output  1  one-cycle pulse on a framing violation
payload_out  output  8  payload byte of FILTER_PID
payload_valid  output  1  payload_out valid
pkt_count  output  CNT_W  headers decoded, saturating
err_count  output  CNT_W  cc_error plus sync_err events, saturating

Behaviour:
- Interface: one clock (clk). Reset rst is asynchronous and active-high.
- Reset values: all outputs 0. State is HUNT, byte index 0, cc_seen 0.
- Only cycles with byte_valid=1 advance anything. With byte_valid=0, state and index hold, and payload_valid, hdr_valid, cc_error and sync_err are 0.
- States:
  - HUNT: wait for byte_valid & sync_in & byte_in==8'h47, then go to HDR1 with index=1.
  - HDR1: capture tei=b[7], pusi=b[6], pid[12:8]=b[4:0].
  - HDR2: capture pid[7:0].
  - HDR3: capture tsc=b[7:6], afc=b[5:4], cc=b[3:0], then go to BODY.
  - BODY: index counts 4..PKT_LEN-1. At index==PKT_LEN-1, the next valid byte is expected to be the sync byte.
    - If that byte has sync_in=1 and byte_in==8'h47: go to HDR1 with index=1.
    - Otherwise: sync_err pulse, go to HUNT, cc_seen cleared.
- Early sync: sync_in=1 with byte_in==8'h47 in HDR1..BODY before the packet is complete aborts the current packet. Response: sync_err pulse, cc_seen cleared, HDR1 with index=1, no hdr_valid for the aborted packet.
- Bad sync byte: sync_in=1 with byte_in!=8'h47 in any state gives a sync_err pulse and a return to HUNT.
- Header output timing: the header fields, hdr_valid and cc_error are registered. They appear in the cycle after the HDR3 byte is accepted. Fields hold until the next header.
- CC check: applies only when the decoded pid==FILTER_PID and tei==0.
  - If cc_seen==0: no check, store cc, set cc_seen.
  - If afc is 2'b01 or 2'b11: expected value is last_cc+1 mod 16. Exception: cc==last_cc is accepted as a duplicate if the previous packet was not itself a duplicate; a second consecutive duplicate is an error.
  - If afc is 2'b00 or 2'b10: expected value is last_cc.
  - On a mismatch: cc_error=1, then resynchronise last_cc to the received cc.
  - pid==13'h1FFF (null) is never checked.
- Payload forwarding: for FILTER_PID packets with tei==0 and afc[0]==1, bytes at index 4..PKT_LEN-1 are forwarded with 1 cycle of latency.
  - payload_valid mirrors byte_valid for those bytes.
  - Adaptation-field bytes are included. Stripping them is the consumer's job.
- pkt_count increments once per hdr_valid.
- err_count increments once per cc_error or sync_err. If both occur in the same cycle it increments by 2.
- Both counters saturate at all-ones.
- An asserted rst at any point, including mid-packet, returns the block to its reset values immediately.

Test Plan:
- Ten back-to-back packets, PID 0x100, afc=01, CC 0..9, byte_valid=1 throughout -> 10 hdr_valid pulses, pid=0x100, cc_error never set, pkt_count=10, err_count=0, 1840 payload_valid cycles.
- CC sequence 3,4,6 on PID 0x100 -> cc_error on the third header only, err_count=1. Then CC 7 -> no error.
- CC sequence 5,5,5 with afc=01 -> first duplicate accepted, cc_error on the third header. CC 5,5 with afc=10 -> no error.
- Sync byte replaced by 0x00 after packet 2 (sync_in=0) -> sync_err pulse, HUNT entered. Next valid 0x47 with sync_in -> decoding resumes with no CC check on the first packet.
- PID 0x1FFF and PID 0x200 packets with random CC interleaved -> hdr_valid for each, no cc_error, no payload_valid.
- byte_valid toggling 1/0 every cycle mid-packet, and rst asserted at index 100 -> all outputs 0 immediately. Following packet decodes from HUNT correctly.

Source files
------------

// File: rtl/ts_header_parser.sv
// MPEG-2 TS packet framer and header decoder with CC check and
// payload forwarding for one selected PID, plus QoS statistics.
module ts_header_parser #(
    parameter logic [12:0] FILTER_PID = 13'h0100,
    parameter int unsigned PKT_LEN    = 188,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       byte_in,
    input  logic             byte_valid,
    input  logic             sync_in,
    output logic             hdr_valid,
    output logic [12:0]      pid,
    output logic             tei,
    output logic             pusi,
    output logic [1:0]       tsc,
    output logic [1:0]       afc,
    output logic [3:0]       cc,
    output logic             cc_error,
    output logic             sync_err,
    output logic [7:0]       payload_out,
    output logic             payload_valid,
    output logic [CNT_W-1:0] pkt_count,
    output logic [CNT_W-1:0] err_count
);
    localparam int unsigned IDX_W = $clog2(PKT_LEN + 1);

    typedef enum logic [2:0] {HUNT, HDR1, HDR2, HDR3, BODY} state_t;

    state_t           state_q;
    logic [IDX_W-1:0] idx_q;
    logic             tei_s_q, pusi_s_q;
    logic [12:0]      pid_s_q;
    logic             cc_seen_q, dup_q, fwd_q;
    logic [3:0]       last_cc_q;

    logic             hdr_valid_q, tei_q, pusi_q, cc_error_q, sync_err_q;
    logic [12:0]      pid_q;
    logic [1:0]       tsc_q, afc_q;
    logic [3:0]       cc_q;
    logic [7:0]       payload_q;
    logic             payload_valid_q;
    logic [CNT_W-1:0] pkt_count_q, err_count_q;
    logic [CNT_W-1:0] pkt_count_d, err_count_d;

    logic             is_sync, bad_sync, at_end;
    logic             hdr_ev, sync_ev, cc_ev;
    logic             chk, cc_err_d, dup_d;
    logic [1:0]       n_err;
    logic [CNT_W:0]   pkt_sum, err_sum;

    assign is_sync  = sync_in && (byte_in == 8'h47);
    assign bad_sync = sync_in && (byte_in != 8'h47);
    // idx == PKT_LEN means the whole packet is in and a sync byte is due
    assign at_end   = (state_q == BODY) && (idx_q == IDX_W'(PKT_LEN));

    assign hdr_ev  = byte_valid && (state_q == HDR3) && !sync_in;
    assign sync_ev = byte_valid && (bad_sync ||
                     (is_sync && (state_q != HUNT) && !at_end) ||
                     (at_end && !is_sync));

    always_comb begin
        chk      = (pid_s_q == FILTER_PID) && !tei_s_q && (pid_s_q != 13'h1FFF);
        cc_err_d = 1'b0;
        dup_d    = 1'b0;
        if (chk && cc_seen_q) begin
            if (byte_in[4]) begin
                if (byte_in[3:0] == last_cc_q + 4'd1) begin
                    dup_d = 1'b0;
                end else if ((byte_in[3:0] == last_cc_q) && !dup_q) begin
                    dup_d = 1'b1;
                end else begin
                    cc_err_d = 1'b1;
                end
            end else begin
                cc_err_d = (byte_in[3:0] != last_cc_q);
            end
        end
    end

    assign cc_ev   = hdr_ev && cc_err_d;
    assign n_err   = {1'b0, cc_ev} + {1'b0, sync_ev};
    assign pkt_sum = {1'b0, pkt_count_q} + (CNT_W+1)'(hdr_ev);
    assign err_sum = {1'b0, err_count_q} + (CNT_W+1)'(n_err);
    assign pkt_count_d = pkt_sum[CNT_W] ? '1 : pkt_sum[CNT_W-1:0];
    assign err_count_d = err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= HUNT;
            idx_q           <= '0;
            tei_s_q         <= 1'b0;
            pusi_s_q        <= 1'b0;
            pid_s_q         <= '0;
            cc_seen_q       <= 1'b0;
            dup_q           <= 1'b0;
            fwd_q           <= 1'b0;
            last_cc_q       <= '0;
            hdr_valid_q     <= 1'b0;
            tei_q           <= 1'b0;
            pusi_q          <= 1'b0;
            pid_q           <= '0;
            tsc_q           <= '0;
            afc_q           <= '0;
            cc_q            <= '0;
            cc_error_q      <= 1'b0;
            sync_err_q      <= 1'b0;
            payload_q       <= '0;
            payload_valid_q <= 1'b0;
            pkt_count_q     <= '0;
            err_count_q     <= '0;
        end else begin
            hdr_valid_q     <= 1'b0;
            cc_error_q      <= 1'b0;
            sync_err_q      <= 1'b0;
            payload_valid_q <= 1'b0;
            if (byte_valid) begin
                sync_err_q  <= sync_ev;
                pkt_count_q <= pkt_count_d;
                err_count_q <= err_count_d;
                if (bad_sync) begin
                    state_q   <= HUNT;
                    idx_q     <= '0;
                    cc_seen_q <= 1'b0;
                end else if (is_sync) begin
                    state_q <= HDR1;
                    idx_q   <= IDX_W'(1);
                    if ((state_q != HUNT) && !at_end) cc_seen_q <= 1'b0;
                end else begin
                    unique case (state_q)
                        HUNT: begin
                        end
                        HDR1: begin
                            tei_s_q        <= byte_in[7];
                            pusi_s_q       <= byte_in[6];
                            pid_s_q[12:8]  <= byte_in[4:0];
                            state_q        <= HDR2;
                            idx_q          <= IDX_W'(2);
                        end
                        HDR2: begin
                            pid_s_q[7:0] <= byte_in;
                            state_q      <= HDR3;
                            idx_q        <= IDX_W'(3);
                        end
                        HDR3: begin
                            hdr_valid_q <= 1'b1;
                            cc_error_q  <= cc_err_d;
                            pid_q       <= pid_s_q;
                            tei_q       <= tei_s_q;
                            pusi_q      <= pusi_s_q;
                            tsc_q       <= byte_in[7:6];
                            afc_q       <= byte_in[5:4];
                            cc_q        <= byte_in[3:0];
                            fwd_q       <= (pid_s_q == FILTER_PID) && !tei_s_q
                                           && byte_in[4];
                            if (chk) begin
                                cc_seen_q <= 1'b1;
                                last_cc_q <= byte_in[3:0];
                                dup_q     <= dup_d;
                            end
                            state_q <= BODY;
                            idx_q   <= IDX_W'(4);
                        end
                        BODY: begin
                            if (at_end) begin
                                state_q   <= HUNT;
                                idx_q     <= '0;
                                cc_seen_q <= 1'b0;
                            end else begin
                                idx_q <= idx_q + IDX_W'(1);
                                if (fwd_q) begin
                                    payload_q       <= byte_in;
                                    payload_valid_q <= 1'b1;
                                end
                            end
                        end
                        default: begin
                            state_q <= HUNT;
                            idx_q   <= '0;
                        end
                    endcase
                end
            end
        end
    end

    assign hdr_valid     = hdr_valid_q;
    assign pid           = pid_q;
    assign tei           = tei_q;
    assign pusi          = pusi_q;
    assign tsc           = tsc_q;
    assign afc           = afc_q;
    assign cc            = cc_q;
    assign cc_error      = cc_error_q;
    assign sync_err      = sync_err_q;
    assign payload_out   = payload_q;
    assign payload_valid = payload_valid_q;
    assign pkt_count     = pkt_count_q;
    assign err_count     = err_count_q;
endmodule

// File: tb/tb_ts_header_parser.sv
// Directed bench for ts_header_parser: framing, CC check, payload,
// sync errors, statistics and asynchronous reset.
module tb_ts_header_parser;
    localparam int PKT_LEN = 188;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  byte_in = '0;
    logic        byte_valid = 1'b0;
    logic        sync_in = 1'b0;
    logic        hdr_valid, tei, pusi, cc_error, sync_err, payload_valid;
    logic [12:0] pid;
    logic [1:0]  tsc, afc;
    logic [3:0]  cc;
    logic [7:0]  payload_out;
    logic [15:0] pkt_count, err_count;

    int checks = 0;
    int failures = 0;

    int n_hdr = 0, n_ccerr = 0, n_serr = 0, n_pay = 0, pay_sum = 0;
    int hdr_pid = 0, hdr_cc = 0, ccerr_cc = -1;
    int b_hdr, b_ccerr, b_serr, b_pay, b_sum;
    int exp_sum;

    ts_header_parser dut (
        .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid),
        .sync_in(sync_in), .hdr_valid(hdr_valid), .pid(pid), .tei(tei),
        .pusi(pusi), .tsc(tsc), .afc(afc), .cc(cc), .cc_error(cc_error),
        .sync_err(sync_err), .payload_out(payload_out),
        .payload_valid(payload_valid), .pkt_count(pkt_count),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (hdr_valid) begin
                n_hdr++;
                hdr_pid = int'(pid);
                hdr_cc  = int'(cc);
            end
            if (cc_error) begin
                n_ccerr++;
                ccerr_cc = int'(cc);
            end
            if (sync_err) n_serr++;
            if (payload_valid) begin
                n_pay++;
                pay_sum += int'(payload_out);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int psum(input int c);
        int s = 0;
        for (int i = 4; i < PKT_LEN; i++) s += (i + 3 * c) & 255;
        return s;
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic s);
        @(negedge clk);
        byte_in    = b;
        sync_in    = s;
        byte_valid = 1'b1;
    endtask

    task automatic gap_cycle();
        @(negedge clk);
        byte_valid = 1'b0;
        sync_in    = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) gap_cycle();
        #1;
    endtask

    task automatic send_pkt(input logic [12:0] p, input logic t,
                            input logic [1:0] a, input int c,
                            input bit gap, input int nb);
        logic [7:0] b;
        for (int i = 0; i < PKT_LEN && i < nb; i++) begin
            if (i == 0)      b = 8'h47;
            else if (i == 1) b = {t, 1'b1, 1'b0, p[12:8]};
            else if (i == 2) b = p[7:0];
            else if (i == 3) b = {2'b00, a, 4'(c)};
            else             b = 8'((i + 3 * c) & 255);
            send_byte(b, i == 0);
            if (gap) gap_cycle();
        end
    endtask

    task automatic do_reset();
        byte_valid = 1'b0;
        sync_in    = 1'b0;
        rst        = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        b_hdr = n_hdr; b_ccerr = n_ccerr; b_serr = n_serr;
        b_pay = n_pay; b_sum = pay_sum;
    endtask

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_hdr_valid", 32'(hdr_valid), 0);
        chk("rst_pid", 32'(pid), 0);
        chk("rst_fields", {tei, pusi, tsc, afc, cc}, 0);
        chk("rst_pulses", {cc_error, sync_err, payload_valid}, 0);
        chk("rst_counts", {pkt_count, err_count}, 0);
        do_reset();

        // ten back-to-back packets, CC 0..9
        exp_sum = 0;
        for (int k = 0; k < 10; k++) begin
            send_pkt(13'h100, 1'b0, 2'b01, k, 1'b0, PKT_LEN);
            exp_sum += psum(k);
        end
        idle(2);
        chk("g1_hdr_n", n_hdr - b_hdr, 10);
        chk("g1_pid", hdr_pid, 32'h100);
        chk("g1_cc", 32'(cc), 9);
        chk("g1_ccerr", n_ccerr - b_ccerr, 0);
        chk("g1_pkt_count", 32'(pkt_count), 10);
        chk("g1_err_count", 32'(err_count), 0);
        chk("g1_pay_n", n_pay - b_pay, 1840);
        chk("g1_pay_sum", pay_sum - b_sum, exp_sum);

        // CC 3,4,6 then 7
        do_reset();
        send_pkt(13'h100, 1'b0, 2'b01, 3, 1'b0, PKT_LEN);
        send_pkt(13'h100, 1'b0, 2'b01, 4, 1'b0, PKT_LEN);
        idle(1);
        chk("g2_no_err_yet", n_ccerr - b_ccerr, 0);
        send_pkt(13'h100, 1'b0, 2'b01, 6, 1'b0, PKT_LEN);
        idle(1);
        chk("g2_ccerr", n_ccerr - b_ccerr, 1);
        chk("g2_ccerr_cc", ccerr_cc, 6);
        chk("g2_err_count", 32'(err_count), 1);
        send_pkt(13'h100, 1'b0, 2'b01, 7, 1'b0, PKT_LEN);
        idle(1);
        chk("g2_cc7_ok", n_ccerr - b_ccerr, 1);
        chk("g2_err_count2", 32'(err_count), 1);

        // duplicates 5,5,5 (afc=01) then 5,5 (afc=10)
        do_reset();
        send_pkt(13'h100, 1'b0, 2'b01, 5, 1'b0, PKT_LEN);
        send_pkt(13'h100, 1'b0, 2'b01, 5, 1'b0, PKT_LEN);
        idle(1);
        chk("g3_dup_ok", n_ccerr - b_ccerr, 0);
        send_pkt(13'h100, 1'b0, 2'b01, 5, 1'b0, PKT_LEN);
        idle(1);
        chk("g3_dup2_err", n_ccerr - b_ccerr, 1);
        send_pkt(13'h100, 1'b0, 2'b10, 5, 1'b0, PKT_LEN);
        send_pkt(13'h100, 1'b0, 2'b10, 5, 1'b0, PKT_LEN);
        idle(1);
        chk("g3_afc10_ok", n_ccerr - b_ccerr, 1);
        chk("g3_err_count", 32'(err_count), 1);
        chk("g3_afc", 32'(afc), 2);

        // missing sync byte, HUNT, resume without CC check
        do_reset();
        send_pkt(13'h100, 1'b0, 2'b01, 0, 1'b0, PKT_LEN);
        send_pkt(13'h100, 1'b0, 2'b01, 1, 1'b0, PKT_LEN);
        send_byte(8'h00, 1'b0);
        send_byte(8'h47, 1'b0);
        send_byte(8'h12, 1'b0);
        idle(1);
        chk("g4_sync_err", n_serr - b_serr, 1);
        chk("g4_err_count", 32'(err_count), 1);
        send_pkt(13'h100, 1'b0, 2'b01, 9, 1'b0, PKT_LEN);
        send_pkt(13'h100, 1'b0, 2'b01, 10, 1'b0, PKT_LEN);
        idle(2);
        chk("g4_hdr_n", n_hdr - b_hdr, 4);
        chk("g4_ccerr", n_ccerr - b_ccerr, 0);
        chk("g4_pkt_count", 32'(pkt_count), 4);
        chk("g4_cc", hdr_cc, 10);

        // null and foreign PIDs interleaved
        do_reset();
        send_pkt(13'h100, 1'b0, 2'b01, 0, 1'b0, PKT_LEN);
        send_pkt(13'h1FFF, 1'b0, 2'b01, 7, 1'b0, PKT_LEN);
        idle(1);
        chk("g5_null_pid", 32'(pid), 32'h1FFF);
        send_pkt(13'h200, 1'b0, 2'b01, 3, 1'b0, PKT_LEN);
        send_pkt(13'h1FFF, 1'b0, 2'b01, 12, 1'b0, PKT_LEN);
        send_pkt(13'h200, 1'b0, 2'b11, 9, 1'b0, PKT_LEN);
        send_pkt(13'h100, 1'b0, 2'b01, 1, 1'b0, PKT_LEN);
        idle(2);
        chk("g5_hdr_n", n_hdr - b_hdr, 6);
        chk("g5_ccerr", n_ccerr - b_ccerr, 0);
        chk("g5_pay_n", n_pay - b_pay, 368);
        chk("g5_pay_sum", pay_sum - b_sum, psum(0) + psum(1));

        // early sync abort and bad sync byte
        do_reset();
        send_pkt(13'h100, 1'b0, 2'b01, 0, 1'b0, PKT_LEN);
        send_pkt(13'h100, 1'b0, 2'b01, 1, 1'b0, 2);
        send_pkt(13'h100, 1'b0, 2'b01, 9, 1'b0, PKT_LEN);
        idle(1);
        chk("g7_early_serr", n_serr - b_serr, 1);
        chk("g7_early_hdr", n_hdr - b_hdr, 2);
        chk("g7_early_ccerr", n_ccerr - b_ccerr, 0);
        send_pkt(13'h100, 1'b0, 2'b01, 10, 1'b0, 60);
        send_byte(8'h12, 1'b1);
        send_pkt(13'h100, 1'b0, 2'b01, 3, 1'b0, PKT_LEN);
        idle(2);
        chk("g7_bad_serr", n_serr - b_serr, 2);
        chk("g7_ccerr", n_ccerr - b_ccerr, 0);
        chk("g7_pkt_count", 32'(pkt_count), 4);
        chk("g7_err_count", 32'(err_count), 2);

        // toggling byte_valid, then reset mid-packet
        do_reset();
        send_pkt(13'h100, 1'b0, 2'b01, 0, 1'b1, PKT_LEN);
        idle(2);
        chk("g6_gap_hdr", n_hdr - b_hdr, 1);
        chk("g6_gap_pay_n", n_pay - b_pay, 184);
        chk("g6_gap_pay_sum", pay_sum - b_sum, psum(0));
        send_pkt(13'h100, 1'b0, 2'b01, 1, 1'b0, 101);
        @(posedge clk);
        #2;
        chk("g6_pre_rst_pv", 32'(payload_valid), 1);
        rst = 1'b1;
        byte_valid = 1'b0;
        #1;
        chk("g6_rst_pulses", {hdr_valid, cc_error, sync_err, payload_valid}, 0);
        chk("g6_rst_fields", {pid, tei, pusi, tsc, afc, cc}, 0);
        chk("g6_rst_counts", {pkt_count, err_count}, 0);
        chk("g6_rst_payload", 32'(payload_out), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        b_hdr = n_hdr; b_ccerr = n_ccerr;
        send_pkt(13'h100, 1'b0, 2'b01, 5, 1'b0, PKT_LEN);
        idle(2);
        chk("g6_post_hdr", n_hdr - b_hdr, 1);
        chk("g6_post_pid", hdr_pid, 32'h100);
        chk("g6_post_cc", hdr_cc, 5);
        chk("g6_post_ccerr", n_ccerr - b_ccerr, 0);
        chk("g6_post_pkt_count", 32'(pkt_count), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
